// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle between the timing generator and its consumers.
//   en           pixel enable into the generator (low = hold)
//   hcount/vcount current pixel / line
//   hsync/vsync  sync levels (polarity set by the generator parameters)
//   hblnk/vblnk/blnk blanking flags
//   line_start/frame_start single-enabled-cycle strobes at line / frame wrap
// master = generator side, slave = consumer side (drives en).
interface vga_timing_if #(
  parameter int CNT_W = 11
);
  logic             en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic             blnk;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  en,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, blnk, line_start, frame_start
  );

  modport slave (
    output en,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, blnk, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing source (default 800x600@60, 40 MHz).
// Ports:
//   clk  pixel clock, posedge
//   rst  asynchronous, active-high reset; returns to position (0,0)
//   tim  vga_timing_if.master: en in; counters, syncs, blanks, strobes out
// Every output is a register loaded from decodes of the *next* counter values,
// so all outputs describe the same (hcount,vcount) they are presented with.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 11
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master tim
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             lstart_q, lstart_d;
  logic             fstart_q, fstart_d;
  logic             h_wrap, v_wrap;

  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (h_wrap) vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
    // vcount_d only moves when hcount_d is 0, so vsync can only change there.
    hsync_d  = ((hcount_d >= HS_ON) && (hcount_d < HS_OFF)) ? HS_POL : ~HS_POL;
    vsync_d  = ((vcount_d >= VS_ON) && (vcount_d < VS_OFF)) ? VS_POL : ~VS_POL;
    hblnk_d  = (hcount_d >= H_ACT);
    vblnk_d  = (vcount_d >= V_ACT);
    lstart_d = h_wrap;
    fstart_d = h_wrap & v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
    end else if (tim.en) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
    end
  end

  assign tim.hcount      = hcount_q;
  assign tim.vcount      = vcount_q;
  assign tim.hsync       = hsync_q;
  assign tim.vsync       = vsync_q;
  assign tim.hblnk       = hblnk_q;
  assign tim.vblnk       = vblnk_q;
  assign tim.blnk        = hblnk_q | vblnk_q;
  assign tim.line_start  = lstart_q;
  assign tim.frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two generators on one clock -- A with default 800x600 timing,
// B with tiny timing (H 8/2/3/2, V 4/1/2/1, active-low hsync) so whole frames fit.
// A behavioural raster model pushes the expected output word into a per-DUT queue
// at every clock edge; each test pops and compares at the following negedge.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hs, vs, hb, vb, b, ls, fs;
  } obs_t;

  localparam obs_t RST_A = '{h:11'd0, v:11'd0, hs:1'b0, vs:1'b0, hb:1'b0, vb:1'b0, b:1'b0, ls:1'b0, fs:1'b0};
  localparam obs_t RST_B = '{h:11'd0, v:11'd0, hs:1'b1, vs:1'b0, hb:1'b0, vb:1'b0, b:1'b0, ls:1'b0, fs:1'b0};

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if #(.CNT_W(11)) ifa ();
  vga_timing_if #(.CNT_W(11)) ifb ();

  vga_timing_gen u_a (.clk(clk), .rst(rst_a), .tim(ifa));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(11)
  ) u_b (.clk(clk), .rst(rst_b), .tim(ifb));

  int total = 0;
  int bad   = 0;

  obs_t qa[$];
  obs_t qb[$];
  int   mha = 0, mva = 0, mhb = 0, mvb = 0;
  obs_t cur_a = RST_A;
  obs_t cur_b = RST_B;
  obs_t ga, gb, xa, xb;

  function automatic obs_t decode(int h, int v, logic ls, logic fs,
                                  int ha, int hf, int hsw, int va, int vf, int vsw,
                                  logic hp, logic vp);
    obs_t o;
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    o.hb = (h >= ha);
    o.vb = (v >= va);
    o.b  = o.hb | o.vb;
    o.ls = ls;
    o.fs = fs;
    return o;
  endfunction

  task automatic adv(inout int h, inout int v, output logic ls, output logic fs,
                     input int ht, input int vt);
    ls = 1'b0;
    fs = 1'b0;
    if (h == ht - 1) begin
      h  = 0;
      ls = 1'b1;
      if (v == vt - 1) begin
        v  = 0;
        fs = 1'b1;
      end else v = v + 1;
    end else h = h + 1;
  endtask

  function automatic obs_t sample_a();
    obs_t o;
    o.h = ifa.hcount; o.v = ifa.vcount; o.hs = ifa.hsync; o.vs = ifa.vsync;
    o.hb = ifa.hblnk; o.vb = ifa.vblnk; o.b = ifa.blnk;
    o.ls = ifa.line_start; o.fs = ifa.frame_start;
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.h = ifb.hcount; o.v = ifb.vcount; o.hs = ifb.hsync; o.vs = ifb.vsync;
    o.hb = ifb.hblnk; o.vb = ifb.vblnk; o.b = ifb.blnk;
    o.ls = ifb.line_start; o.fs = ifb.frame_start;
    return o;
  endfunction

  // One clock: model both generators at the edge, queue expectations, return at negedge.
  task automatic tick();
    logic ls, fs;
    @(posedge clk);
    if (rst_a) begin
      mha = 0; mva = 0; cur_a = RST_A;
    end else if (ifa.en) begin
      adv(mha, mva, ls, fs, 1056, 628);
      cur_a = decode(mha, mva, ls, fs, 800, 40, 128, 600, 1, 4, 1'b1, 1'b1);
    end
    qa.push_back(cur_a);
    if (rst_b) begin
      mhb = 0; mvb = 0; cur_b = RST_B;
    end else if (ifb.en) begin
      adv(mhb, mvb, ls, fs, 15, 8);
      cur_b = decode(mhb, mvb, ls, fs, 8, 2, 3, 4, 1, 2, 1'b0, 1'b1);
    end
    qb.push_back(cur_b);
    @(negedge clk);
  endtask

  task automatic test_reset();
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      ga = sample_a(); gb = sample_b(); xa = qa.pop_front(); xb = qb.pop_front();
      total += 2;
      if (ga !== RST_A) begin bad++; $display("FAIL reset_a got=%h exp=%h", ga, RST_A); end
      if (gb !== RST_B) begin bad++; $display("FAIL reset_b got=%h exp=%h", gb, RST_B); end
      total += 2;
      if (ga !== xa) begin bad++; $display("FAIL reset_sb_a got=%h exp=%h", ga, xa); end
      if (gb !== xb) begin bad++; $display("FAIL reset_sb_b got=%h exp=%h", gb, xb); end
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic test_line();
    logic prev_hs = 1'b0, prev_hb = 1'b0;
    int   hs_len = 0, rises = 0, last_rise = 0;
    ifa.en = 1'b1;
    for (int i = 0; i < 2122; i++) begin
      tick();
      ga = sample_a(); gb = sample_b(); xa = qa.pop_front(); xb = qb.pop_front();
      total += 2;
      if (ga !== xa) begin bad++; $display("FAIL line_a got=%h exp=%h", ga, xa); end
      if (gb !== xb) begin bad++; $display("FAIL line_hold_b got=%h exp=%h", gb, xb); end
      if (ga.hs && !prev_hs) begin
        rises++;
        total++;
        if (ga.h !== 11'd840) begin bad++; $display("FAIL hsync_start got=%0d exp=840", ga.h); end
        if (rises > 1) begin
          total++;
          if (i - last_rise != 1056) begin bad++; $display("FAIL hsync_period got=%0d exp=1056", i - last_rise); end
        end
        last_rise = i;
      end
      if (!ga.hs && prev_hs) begin
        total++;
        if (hs_len != 128) begin bad++; $display("FAIL hsync_width got=%0d exp=128", hs_len); end
        hs_len = 0;
      end
      if (ga.hs) hs_len++;
      if (ga.hb && !prev_hb) begin
        total++;
        if (ga.h !== 11'd800) begin bad++; $display("FAIL hblnk_rise got=%0d exp=800", ga.h); end
      end
      if (!ga.hb && prev_hb) begin
        total++;
        if (ga.h !== 11'd0) begin bad++; $display("FAIL hblnk_fall got=%0d exp=0", ga.h); end
      end
      prev_hs = ga.hs;
      prev_hb = ga.hb;
    end
    total++;
    if (rises != 2) begin bad++; $display("FAIL hsync_count got=%0d exp=2", rises); end
  endtask

  task automatic test_enable();
    int sh = mha, sv = mva;
    for (int i = 0; i < 2112; i++) begin
      ifa.en = (i % 2 == 0);
      tick();
      ga = sample_a(); gb = sample_b(); xa = qa.pop_front(); xb = qb.pop_front();
      total += 2;
      if (ga !== xa) begin bad++; $display("FAIL enable_a got=%h exp=%h", ga, xa); end
      if (gb !== xb) begin bad++; $display("FAIL enable_hold_b got=%h exp=%h", gb, xb); end
    end
    total++;
    if (ga.h !== 11'(sh) || ga.v !== 11'(sv + 1))
      begin bad++; $display("FAIL enable_line_len got=(%0d,%0d) exp=(%0d,%0d)", ga.h, ga.v, sh, sv + 1); end
  endtask

  task automatic test_mid_reset();
    int   guard = 0;
    logic seen_fs = 1'b0;
    ifa.en = 1'b1;
    while (mha != 500 && guard < 2000) begin
      tick();
      guard++;
      ga = sample_a(); gb = sample_b(); xa = qa.pop_front(); xb = qb.pop_front();
      total += 2;
      if (ga !== xa) begin bad++; $display("FAIL midrst_run_a got=%h exp=%h", ga, xa); end
      if (gb !== xb) begin bad++; $display("FAIL midrst_hold_b got=%h exp=%h", gb, xb); end
    end
    total++;
    if (mha != 500) begin bad++; $display("FAIL midrst_reach got=%0d exp=500", mha); end
    // Assert reset between edges: outputs must drop without a clock edge.
    #2 rst_a = 1'b1;
    #1;
    ga = sample_a();
    total++;
    if (ga !== RST_A) begin bad++; $display("FAIL midrst_async got=%h exp=%h", ga, RST_A); end
    mha = 0; mva = 0; cur_a = RST_A;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tick();
      ga = sample_a(); xa = qa.pop_front(); void'(qb.pop_front());
      total++;
      if (ga !== xa) begin bad++; $display("FAIL midrst_hold_a got=%h exp=%h", ga, xa); end
    end
    rst_a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      ga = sample_a(); xa = qa.pop_front(); void'(qb.pop_front());
      total++;
      if (ga !== xa) begin bad++; $display("FAIL midrst_resume_a got=%h exp=%h", ga, xa); end
      if (ga.fs) seen_fs = 1'b1;
    end
    total += 2;
    if (ga.h !== 11'd300 || ga.v !== 11'd0) begin bad++; $display("FAIL midrst_pos got=(%0d,%0d) exp=(300,0)", ga.h, ga.v); end
    if (seen_fs) begin bad++; $display("FAIL midrst_no_fs got=1 exp=0"); end
    ifa.en = 1'b0;
  endtask

  task automatic test_small_frame();
    int fs_cnt = 0, hmax = 0, vmax = 0;
    ifa.en = 1'b0;
    ifb.en = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tick();
      ga = sample_a(); gb = sample_b(); xa = qa.pop_front(); xb = qb.pop_front();
      total += 3;
      if (gb !== xb) begin bad++; $display("FAIL small_b got=%h exp=%h", gb, xb); end
      if (ga !== xa) begin bad++; $display("FAIL small_hold_a got=%h exp=%h", ga, xa); end
      if (gb.hs !== !(gb.h >= 10 && gb.h <= 12))
        begin bad++; $display("FAIL small_hsync got=%b exp=%b at h=%0d", gb.hs, !(gb.h >= 10 && gb.h <= 12), gb.h); end
      if (gb.fs) begin
        fs_cnt++;
        total++;
        if (gb.h !== 11'd0 || gb.v !== 11'd0 || gb.ls !== 1'b1)
          begin bad++; $display("FAIL small_fs_pos got=(%0d,%0d,ls=%b) exp=(0,0,ls=1)", gb.h, gb.v, gb.ls); end
      end
      if (int'(gb.h) > hmax) hmax = int'(gb.h);
      if (int'(gb.v) > vmax) vmax = int'(gb.v);
    end
    total += 3;
    if (fs_cnt != 2) begin bad++; $display("FAIL small_fs_count got=%0d exp=2", fs_cnt); end
    if (hmax != 14) begin bad++; $display("FAIL small_hmax got=%0d exp=14", hmax); end
    if (vmax != 7)  begin bad++; $display("FAIL small_vmax got=%0d exp=7", vmax); end
  endtask

  task automatic test_small_mid_reset();
    int guard = 0, fs_cnt = 0, fs_at = -1;
    ifb.en = 1'b1;
    while (!(mhb == 5 && mvb == 3) && guard < 200) begin
      tick();
      guard++;
      gb = sample_b(); xb = qb.pop_front(); void'(qa.pop_front());
      total++;
      if (gb !== xb) begin bad++; $display("FAIL small_midrst_run got=%h exp=%h", gb, xb); end
    end
    total++;
    if (!(mhb == 5 && mvb == 3)) begin bad++; $display("FAIL small_midrst_reach got=(%0d,%0d) exp=(5,3)", mhb, mvb); end
    #2 rst_b = 1'b1;
    #1;
    gb = sample_b();
    total++;
    if (gb !== RST_B) begin bad++; $display("FAIL small_midrst_async got=%h exp=%h", gb, RST_B); end
    mhb = 0; mvb = 0; cur_b = RST_B;
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 125; i++) begin
      tick();
      gb = sample_b(); xb = qb.pop_front(); void'(qa.pop_front());
      total++;
      if (gb !== xb) begin bad++; $display("FAIL small_midrst_resume got=%h exp=%h", gb, xb); end
      if (gb.fs) begin fs_cnt++; if (fs_at < 0) fs_at = i; end
    end
    total += 2;
    if (fs_cnt != 1) begin bad++; $display("FAIL small_midrst_fs_count got=%0d exp=1", fs_cnt); end
    if (fs_at != 119) begin bad++; $display("FAIL small_midrst_fs_at got=%0d exp=119", fs_at); end
  endtask

  initial begin
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    test_reset();
    test_line();
    test_enable();
    test_mid_reset();
    test_small_frame();
    test_small_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
